modmul_issuer: RTL and testbench

Requester-side front end for the pipelined 255-bit modmul core. Accepts tagged operand pairs over a valid/ready stream and drives them into the modmul A/B inputs. Tracks in-flight operations with a latency-matched valid/tag shift line and captures each D result into a result FIFO. Returns results in order over a valid/ready stream. Because the modmul core has no stall input, a credit scheme guarantees that the FIFO never overflows.

---
 rtl/modmul_pkg.sv | 10 +
 rtl/modmul_res_fifo.sv | 62 ++++++
 rtl/modmul_issuer.sv | 81 ++++++++
 tb/tb_modmul_issuer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modmul_pkg.sv
// Shared definitions for the modmul core and its requester-side front end.
// Field width and core latency live here so every consumer agrees on them.
package modmul_pkg;

  localparam int FIELD_W    = 255;
  localparam int MODMUL_LAT = 9;

  typedef logic [FIELD_W-1:0] fe_t;

endpackage

// File: rtl/modmul_res_fifo.sv
// Synchronous result FIFO with a registered head. A push into an empty FIFO
// shows up on the output one cycle later; push and pop together are legal at any fill level.
module modmul_res_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] remain;
  logic          head_vld;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop     = pop & head_vld;
  assign rd_ptr_nxt = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
  // Entries that were already stored before this edge and survive the pop.
  assign remain     = count - CW'(do_pop);

  // NOTE: storage carries no reset; validity is tracked by count/head_vld,
  // so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
      head     <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr   <= rd_ptr_nxt;
      count    <= count + CW'(push) - CW'(do_pop);
      head_vld <= (remain != '0);
      if (remain != '0) head <= mem[rd_ptr_nxt];
    end
  end

  assign empty = !head_vld;
  assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/modmul_issuer.sv
// Front end for the stall-free pipelined modmul core: issues operand pairs,
// tracks them with a latency-matched valid/tag line and returns results in order.
module modmul_issuer
  import modmul_pkg::*;
#(
  parameter  int FW    = FIELD_W,
  parameter  int LAT   = MODMUL_LAT,
  parameter  int TAGW  = 4,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FW-1:0]   in_a,
  input  logic [FW-1:0]   in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic [FW-1:0]   mul_a,
  output logic [FW-1:0]   mul_b,
  input  logic [FW-1:0]   mul_d,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FW-1:0]   out_d,
  output logic [TAGW-1:0] out_tag,
  output logic [CW-1:0]   inflight
);

  logic [LAT:0]    valid_line;
  logic [TAGW-1:0] tag_line [LAT+1];
  logic            accept;
  logic            push;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW:0]     used;

  // Credits cover both in-flight ops and queued results, so the core can
  // never deliver a product the FIFO has no room for.
  assign used     = (CW+1)'(inflight) + (CW+1)'(fifo_count);
  assign in_ready = rst && !fifo_full && (used < (CW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = valid_line[LAT];

  // NOTE: all state here uses non-blocking assignments so every stage of the
  // delay line samples its predecessor's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a      <= '0;
      mul_b      <= '0;
      valid_line <= '0;
      inflight   <= '0;
      for (int i = 0; i <= LAT; i++) tag_line[i] <= '0;
    end else begin
      mul_a      <= accept ? in_a : '0;
      mul_b      <= accept ? in_b : '0;
      valid_line <= {valid_line[LAT-1:0], accept};
      tag_line[0] <= in_tag;
      for (int i = 1; i <= LAT; i++) tag_line[i] <= tag_line[i-1];
      inflight   <= inflight + CW'(accept) - CW'(push);
    end
  end

  modmul_res_fifo #(
    .W     (FW + TAGW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({mul_d, tag_line[LAT]}),
    .pop       (out_ready),
    .head      ({out_d, out_tag}),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_modmul_issuer.sv
// Directed bench for modmul_issuer: a DEPTH=4 and a DEPTH=12 instance, each
// fed by a behavioural fixed-latency modmul model (mod 2^255-19).
module tb_modmul_issuer;
  import modmul_pkg::*;

  localparam int LAT  = MODMUL_LAT;
  localparam int TAGW = 4;
  localparam logic [511:0] P = (512'd1 << 255) - 512'd19;

  typedef struct {
    logic [TAGW-1:0] tag;
    fe_t             d;
    int              cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic in_valid, in_ready, out_valid, out_ready;
  fe_t in_a, in_b, mul_a, mul_b, mul_d, out_d;
  logic [TAGW-1:0] in_tag, out_tag;
  logic [2:0] inflight;

  // DEPTH=12 instance
  logic in_valid_w, in_ready_w, out_valid_w, out_ready_w;
  fe_t in_a_w, in_b_w, mul_a_w, mul_b_w, mul_d_w, out_d_w;
  logic [TAGW-1:0] in_tag_w, out_tag_w;
  logic [3:0] inflight_w;

  modmul_issuer #(.TAGW(TAGW), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .mul_a(mul_a), .mul_b(mul_b),
    .mul_d(mul_d), .out_valid(out_valid), .out_ready(out_ready),
    .out_d(out_d), .out_tag(out_tag), .inflight(inflight)
  );

  modmul_issuer #(.TAGW(TAGW), .DEPTH(12)) u_dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .in_a(in_a_w), .in_b(in_b_w), .in_tag(in_tag_w), .mul_a(mul_a_w), .mul_b(mul_b_w),
    .mul_d(mul_d_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
    .out_d(out_d_w), .out_tag(out_tag_w), .inflight(inflight_w)
  );

  function automatic fe_t modmul(input fe_t a, input fe_t b);
    logic [511:0] t;
    t = (512'(a) * 512'(b)) % P;
    return fe_t'(t);
  endfunction

  // Core models: no reset and no stall, exactly like the real pipeline.
  fe_t pipe4 [LAT];
  fe_t pipew [LAT];
  always @(posedge clk) begin
    pipe4[0] <= modmul(mul_a, mul_b);
    pipew[0] <= modmul(mul_a_w, mul_b_w);
    for (int i = 1; i < LAT; i++) begin
      pipe4[i] <= pipe4[i-1];
      pipew[i] <= pipew[i-1];
    end
  end
  assign mul_d   = pipe4[LAT-1];
  assign mul_d_w = pipew[LAT-1];

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Result monitors: record every handshake together with its cycle number.
  res_t q4[$];
  res_t qw[$];
  int   cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && out_valid && out_ready)     q4.push_back('{out_tag, out_d, cyc});
    if (rst && out_valid_w && out_ready_w) qw.push_back('{out_tag_w, out_d_w, cyc});
  end

  // Credit invariant, observed through the FIFO occupancy of each instance.
  always @(negedge clk) begin
    if (rst) begin
      check("credit4", 256'(int'(inflight) + int'(u_dut.fifo_count) <= 4), 256'd1);
      check("credit12", 256'(int'(inflight_w) + int'(u_dut_w.fifo_count) <= 12), 256'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  int   first, highs, idx, drops;
  logic acc;

  initial begin
    rst = 1'b0;
    in_valid = 1'b1; in_a = 1; in_b = 1; in_tag = '0; out_ready = 1'b0;
    in_valid_w = 1'b0; in_a_w = '0; in_b_w = '0; in_tag_w = '0; out_ready_w = 1'b0;

    // 1. Reset with in_valid asserted
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_mul_a", mul_a, 0);
      check("rst_mul_b", mul_b, 0);
      check("rst_inflight", inflight, 0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // 2. Single op, latency check
    out_ready = 1'b1;
    q4.delete();
    in_valid = 1'b1; in_a = 2; in_b = 3; in_tag = 5;
    check("single_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("single_inflight", inflight, 1);
    check("single_mul_a", mul_a, 2);
    first = -1; highs = 0;
    for (int k = 0; k <= LAT + 5; k++) begin
      if (out_valid) begin
        if (first < 0) first = k;
        highs++;
      end
      step();
    end
    check("single_lat", 256'(first), 256'(LAT + 2));
    check("single_pulse", 256'(highs), 1);
    check("single_n", 256'(q4.size()), 1);
    if (q4.size() == 1) begin
      check("single_d", q4[0].d, 6);
      check("single_tag", q4[0].tag, 5);
    end
    check("single_inflight_end", inflight, 0);
    check("single_idle_mul_a", mul_a, 0);

    // 3. Back-to-back on DEPTH=12
    out_ready_w = 1'b1;
    qw.delete();
    drops = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid_w = 1'b1; in_a_w = fe_t'(i + 1); in_b_w = 7; in_tag_w = TAGW'(i);
      if (!in_ready_w) drops++;
      step();
    end
    in_valid_w = 1'b0;
    check("b2b_ready", 256'(drops), 0);
    for (int c = 0; c < 40 && qw.size() < 12; c++) step();
    check("b2b_n", 256'(qw.size()), 12);
    for (int i = 0; i < qw.size(); i++) begin
      check($sformatf("b2b_d%0d", i), qw[i].d, 256'(7 * (i + 1)));
      check($sformatf("b2b_tag%0d", i), qw[i].tag, 256'(i));
      check($sformatf("b2b_cyc%0d", i), 256'(qw[i].cyc), 256'(qw[0].cyc + i));
    end

    // 4. Backpressure at DEPTH=4: six offered, four fit
    out_ready = 1'b0;
    q4.delete();
    idx = 0;
    for (int c = 0; c < 80 && q4.size() < 6; c++) begin
      if (c == 20) begin
        check("bp_accepted", 256'(idx), 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_count", u_dut.fifo_count, 4);
        check("bp_inflight", inflight, 0);
        out_ready = 1'b1;
      end
      if (idx < 6) begin
        in_valid = 1'b1; in_a = fe_t'(idx + 1); in_b = 3; in_tag = TAGW'(idx);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_n", 256'(q4.size()), 6);
    for (int i = 0; i < q4.size(); i++) begin
      check($sformatf("bp_d%0d", i), q4[i].d, 256'(3 * (i + 1)));
      check($sformatf("bp_tag%0d", i), q4[i].tag, 256'(i));
    end

    // 5. Pop and push on the same edge with the credit pool exhausted
    repeat (3) step();
    out_ready = 1'b0;
    q4.delete();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = fe_t'(10 + i); in_b = 1; in_tag = TAGW'(8 + i);
      check($sformatf("pp_ready%0d", i), in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    repeat (9) step();
    check("pp_count_pre", u_dut.fifo_count, 3);
    check("pp_inflight_pre", inflight, 1);
    check("pp_valid_pre", out_valid, 1);
    out_ready = 1'b1;
    step();
    check("pp_count_post", u_dut.fifo_count, 3);
    check("pp_inflight_post", inflight, 0);
    for (int c = 0; c < 20 && q4.size() < 4; c++) step();
    repeat (3) step();
    check("pp_n", 256'(q4.size()), 4);
    for (int i = 0; i < q4.size(); i++) begin
      check($sformatf("pp_d%0d", i), q4[i].d, 256'(10 + i));
      check($sformatf("pp_tag%0d", i), q4[i].tag, 256'(8 + i));
    end

    // 6. Reset with 3 ops in flight and 2 results queued (DEPTH=12)
    out_ready_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid_w = 1'b1; in_a_w = fe_t'(i + 1); in_b_w = 2; in_tag_w = TAGW'(i + 1);
      step();
    end
    in_valid_w = 1'b0;
    repeat (7) step();
    check("mid_count", u_dut_w.fifo_count, 2);
    check("mid_inflight", inflight_w, 3);
    check("mid_valid", out_valid_w, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid_w, 0);
    check("mid_rst_inflight", inflight_w, 0);
    check("mid_rst_ready", in_ready_w, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    qw.delete();
    out_ready_w = 1'b1;
    repeat (LAT + 5) step();
    check("mid_stale", 256'(qw.size()), 0);
    in_valid_w = 1'b1; in_a_w = 5; in_b_w = 5; in_tag_w = 7;
    step();
    in_valid_w = 1'b0;
    for (int c = 0; c < 30 && qw.size() < 1; c++) step();
    check("fresh_n", 256'(qw.size()), 1);
    if (qw.size() == 1) begin
      check("fresh_d", qw[0].d, 25);
      check("fresh_tag", qw[0].tag, 7);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
